fpmult_rr_scheduler: RTL and testbench

//  Shares one iterative fixed-point multiplier among NREQ requesters.

---
 rtl/fpmult_rr_scheduler_pkg.sv | 16 +
 rtl/fpmult_rr_scheduler_if.sv | 36 +++
 rtl/fpmult_rr_scheduler_pick.sv | 44 ++++
 rtl/fpmult_rr_scheduler.sv | 110 +++++++++++
 tb/tb_fpmult_rr_scheduler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpmult_rr_scheduler_pkg.sv
// Shared types and helpers for the fixed-point multiplier round-robin scheduler.
// Grant/pointer widths derive from clog2_min1 so NREQ=2 still gets a 1-bit index.
package fpmult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fpmult_rr_scheduler_if.sv
// Requester and multiplier handshake bundle of the scheduler.
// master = scheduler view, slave = requesters plus the attached multiplier.
interface fpmult_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int n    = 32
);
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*n-1:0] req_a;
  logic [NREQ*n-1:0] req_b;
  logic [NREQ-1:0]   resp_val;
  logic [NREQ-1:0]   resp_rdy;
  logic [n-1:0]      resp_c;
  logic              mult_recv_val;
  logic              mult_recv_rdy;
  logic [n-1:0]      mult_a;
  logic [n-1:0]      mult_b;
  logic              mult_send_val;
  logic              mult_send_rdy;
  logic [n-1:0]      mult_c;
  logic              busy;

  modport master (
    input  req_val, req_a, req_b, resp_rdy,
    input  mult_recv_rdy, mult_send_val, mult_c,
    output req_rdy, resp_val, resp_c,
    output mult_recv_val, mult_a, mult_b, mult_send_rdy, busy
  );

  modport slave (
    output req_val, req_a, req_b, resp_rdy,
    output mult_recv_rdy, mult_send_val, mult_c,
    input  req_rdy, resp_val, resp_c,
    input  mult_recv_val, mult_a, mult_b, mult_send_rdy, busy
  );
endinterface

// File: rtl/fpmult_rr_scheduler_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Doubling the request vector turns the wrap into a plain lowest-bit priority encode.
module fpmult_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt_oh,
  output logic [PW-1:0]   o_gnt_idx,
  output logic            o_any
);
  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_mask;
  logic [2*NREQ-1:0] w_sel;
  logic [PW-1:0]     w_idx;
  logic [NREQ-1:0]   w_oh;

  assign w_dbl  = {i_req, i_req};
  assign w_mask = ~(((2*NREQ)'(1) << i_ptr) - (2*NREQ)'(1));
  assign w_sel  = w_dbl & w_mask;

  // Descending scan so the last hit kept is the lowest set bit.
  always_comb begin
    w_idx = '0;
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_idx = PW'((i >= NREQ) ? (i - NREQ) : i);
      end
    end
  end

  always_comb begin
    w_oh = '0;
    if (|i_req) begin
      w_oh[w_idx] = 1'b1;
    end
  end

  assign o_gnt_oh  = w_oh;
  assign o_gnt_idx = w_idx;
  assign o_any     = |i_req;

endmodule

// File: rtl/fpmult_rr_scheduler.sv
// Shares one iterative fixed-point multiplier among NREQ val/rdy requesters, one op at a time.
// Round-robin grant in IDLE; the result returns only to the granted port and is held until taken.
module fpmult_rr_scheduler
  import fpmult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int n    = 32,
  parameter int d    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  fpmult_rr_scheduler_if.master  bus
);
  localparam int PW = clog2_min1(NREQ);

  if (NREQ < 2 || d >= n) begin : g_param_chk
    $error("fpmult_rr_scheduler: NREQ must be >= 2 and d < n");
  end

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_grant;
  logic [n-1:0]    r_a;
  logic [n-1:0]    r_b;
  logic [n-1:0]    r_c;

  logic [NREQ-1:0] w_gnt_oh;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_any;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_resp_val;
  logic [n-1:0]    w_req_a [NREQ];
  logic [n-1:0]    w_req_b [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_req_a[gi] = bus.req_a[gi*n +: n];
    assign w_req_b[gi] = bus.req_b[gi*n +: n];
  end

  fpmult_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req     (bus.req_val),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_ptr_nxt = (r_grant == PW'(NREQ-1)) ? '0 : r_grant + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_gnt_idx;
            r_a     <= w_req_a[w_gnt_idx];
            r_b     <= w_req_b[w_gnt_idx];
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mult_recv_rdy) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mult_send_val) begin
            r_c     <= bus.mult_c;
            r_state <= RESP;
          end
        end
        RESP: begin
          // Only the granted port's ready can retire the response.
          if (bus.resp_rdy[r_grant]) begin
            r_ptr   <= w_ptr_nxt;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_resp_val = '0;
    if (r_state == RESP) begin
      w_resp_val[r_grant] = 1'b1;
    end
  end

  assign bus.req_rdy       = (r_state == IDLE && !reset) ? w_gnt_oh : '0;
  assign bus.resp_val      = w_resp_val;
  assign bus.resp_c        = r_c;
  assign bus.mult_recv_val = (r_state == ISSUE);
  assign bus.mult_a        = r_a;
  assign bus.mult_b        = r_b;
  assign bus.mult_send_rdy = (r_state == WAIT);
  assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_fpmult_rr_scheduler.sv
// Bench for fpmult_rr_scheduler with a behavioural iterative multiplier attached.
module tb_fpmult_rr_scheduler;
  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int D    = 16;
  localparam int LIM  = 300;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;

  fpmult_rr_scheduler_if #(.NREQ(NREQ), .n(N)) bus();

  fpmult_rr_scheduler #(.NREQ(NREQ), .n(N), .d(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Q16.16 signed product, truncated back to 32 bits.
  function automatic logic [31:0] fxmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[47:16];
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Attached multiplier: accepts one op, answers N cycles later, cleared by the shared reset.
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;
  logic        m_rdy  = 1'b1;
  bit          m_rand = 1'b0;

  assign bus.mult_recv_rdy = !m_busy && m_rdy;
  assign bus.mult_send_val = m_busy && (m_cnt >= N);
  assign bus.mult_c        = fxmul(m_a, m_b);

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_rdy  <= 1'b1;
    end else begin
      m_rdy <= m_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!m_busy) begin
        if (bus.mult_recv_val && bus.mult_recv_rdy) begin
          m_busy <= 1'b1;
          m_cnt  <= 0;
          m_a    <= bus.mult_a;
          m_b    <= bus.mult_b;
        end
      end else if (bus.mult_send_val && bus.mult_send_rdy) begin
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[p*32 +: 32] = a;
    bus.req_b[p*32 +: 32] = b;
  endtask

  // One full operation: grant, issue, response (optionally held), retire.
  task automatic do_op(input int hold, input bit drop, output int g, output int wt,
                       output logic [31:0] oc);
    int          t;
    logic [31:0] ea, eb, ec;
    logic [3:0]  one;
    g  = -1;
    oc = '0;
    #1;
    t = 0;
    while (bus.req_rdy === 4'b0 && t < LIM) begin
      @(negedge clk); #1; t++;
    end
    wt = t;
    chk("req_rdy_wait", 64'(t < LIM), 64'd1);
    if (t >= LIM) return;
    g   = rr_pick(bus.req_val, m_ptr);
    one = 4'b0001 << g;
    chk("req_rdy_grant", 64'(bus.req_rdy), 64'(one));
    chk("busy_in_idle", 64'(bus.busy), 64'd0);
    ea = bus.req_a[g*32 +: 32];
    eb = bus.req_b[g*32 +: 32];
    ec = fxmul(ea, eb);
    @(negedge clk);
    if (drop) bus.req_val[g] = 1'b0;
    #1;
    chk("req_rdy_during_op", 64'(bus.req_rdy), 64'd0);
    chk("busy_during_op", 64'(bus.busy), 64'd1);
    t = 0;
    while (bus.resp_val === 4'b0 && t < LIM) begin
      @(negedge clk); #1; t++;
    end
    chk("resp_val_wait", 64'(t < LIM), 64'd1);
    if (t >= LIM) return;
    oc = bus.resp_c;
    chk("resp_val_onehot", 64'(bus.resp_val), 64'(one));
    chk("resp_c", 64'(bus.resp_c), 64'(ec));
    bus.resp_rdy = ~one;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      chk("hold_resp_val", 64'(bus.resp_val), 64'(one));
      chk("hold_resp_c", 64'(bus.resp_c), 64'(ec));
      chk("hold_req_rdy", 64'(bus.req_rdy), 64'd0);
      chk("hold_recv_val", 64'(bus.mult_recv_val), 64'd0);
    end
    bus.resp_rdy = 4'hF;
    @(negedge clk);
    bus.resp_rdy = 4'h0;
    #1;
    chk("resp_val_retired", 64'(bus.resp_val), 64'd0);
    m_ptr = (g + 1) % NREQ;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_rdy"}, 64'(bus.req_rdy), 64'd0);
    chk({tag, "_resp_val"}, 64'(bus.resp_val), 64'd0);
    chk({tag, "_recv_val"}, 64'(bus.mult_recv_val), 64'd0);
    chk({tag, "_send_rdy"}, 64'(bus.mult_send_rdy), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_resp_c"}, 64'(bus.resp_c), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g, wt, t, seen;
    logic [31:0] oc;
    bus.req_val  = '0;
    bus.req_a    = '0;
    bus.req_b    = '0;
    bus.resp_rdy = '0;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;

    // 1.5 * 2.0 on port 0
    set_port(0, 32'h0001_8000, 32'h0002_0000);
    bus.req_val = 4'b0001;
    do_op(0, 1'b1, g, wt, oc);
    chk("t1_port", 64'(g), 64'd0);
    chk("t1_c", 64'(oc), 64'h0003_0000);

    // -1.0 * 0.5 on port 2
    set_port(2, 32'hFFFF_0000, 32'h0000_8000);
    bus.req_val = 4'b0100;
    do_op(0, 1'b1, g, wt, oc);
    chk("t2_port", 64'(g), 64'd2);
    chk("t2_c", 64'(oc), 64'hFFFF_8000);

    // All ports requesting continuously: strict rotation from a fresh pointer.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    m_rand = 1'b1;
    for (int p = 0; p < NREQ; p++) set_port(p, $urandom, $urandom);
    bus.req_val = 4'hF;
    for (int k = 0; k < 8; k++) begin
      do_op(0, 1'b0, g, wt, oc);
      chk("t3_order", 64'(g), 64'(k % NREQ));
      if (g >= 0) set_port(g, $urandom, $urandom);
    end
    bus.req_val = 4'h0;
    m_rand = 1'b0;

    // Response backpressure on port 1 for 10 cycles.
    set_port(1, 32'h0004_0000, 32'hFFFE_0000);
    bus.req_val = 4'b0010;
    do_op(10, 1'b1, g, wt, oc);
    chk("t4_c", 64'(oc), 64'hFFF8_0000);

    // Reset while port 3's op sits in WAIT.
    set_port(3, $urandom, $urandom);
    bus.req_val = 4'b1000;
    #1;
    t = 0;
    while (bus.req_rdy === 4'b0 && t < LIM) begin @(negedge clk); #1; t++; end
    chk("t5_grant_wait", 64'(t < LIM), 64'd1);
    @(negedge clk);
    bus.req_val = 4'b0;
    #1;
    t = 0;
    while (bus.mult_send_rdy !== 1'b1 && t < LIM) begin @(negedge clk); #1; t++; end
    chk("t5_wait_state", 64'(t < LIM), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("t5_reset");
    reset = 1'b0;
    m_ptr = 0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (bus.resp_val !== 4'b0 || bus.busy !== 1'b0) seen++;
    end
    chk("t5_no_stale", 64'(seen), 64'd0);
    set_port(3, 32'h0003_0000, 32'h0003_0000);
    bus.req_val = 4'b1000;
    do_op(0, 1'b1, g, wt, oc);
    chk("t5_port", 64'(g), 64'd3);
    chk("t5_c", 64'(oc), 64'h0009_0000);

    // Port 1 back-to-back with port 0 idle: pointer wraps past 2,3,0 back to 1.
    set_port(1, 32'h0000_4000, 32'h0008_0000);
    bus.req_val = 4'b0010;
    do_op(0, 1'b0, g, wt, oc);
    chk("t6_first_port", 64'(g), 64'd1);
    chk("t6_first_c", 64'(oc), 64'h0002_0000);
    set_port(1, 32'h0001_0000, 32'h8000_0000);
    do_op(0, 1'b1, g, wt, oc);
    chk("t6_second_port", 64'(g), 64'd1);
    chk("t6_idle_gap", 64'(wt), 64'd0);
    chk("t6_second_c", 64'(oc), 64'h8000_0000);

    // Random mixes of requesters, holds and multiplier stalls.
    m_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      for (int p = 0; p < NREQ; p++) set_port(p, $urandom, $urandom);
      bus.req_val = 4'($urandom_range(1, 15));
      do_op($urandom_range(0, 3), 1'($urandom_range(0, 1)), g, wt, oc);
      bus.req_val = 4'h0;
    end
    m_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
